fifo_sync_cfg: RTL and testbench

//  - Single-clock FIFO; parametrised successor of the fifo_pkg FIFO family.
//  - Configurable data width and depth; standard or first-word-fall-through (FWFT) read mode.
//  - Provides occupancy count, programmable almost-full/almost-empty flags,

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_ram_dp.sv | 66 ++++++
 rtl/fifo_sync_cfg.sv | 164 ++++++++++++++++
 tb/tb_fifo_sync_cfg.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared types for the FIFO family.
//   rd_mode_e    : read-port flavour (standard registered read or FWFT)
//   fifo_cfg_st  : bundle of the elaboration-time configuration of one FIFO
//   ptr_t/cnt_t  : pointer and occupancy types for the default 8-entry FIFO
//                  (one extra bit: wrap bit for pointers, DEPTH for counts)
//   depth_of()   : number of entries for a given address width
// ---------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic {
    RD_STD  = 1'b0,
    RD_FWFT = 1'b1
  } rd_mode_e;

  typedef struct packed {
    int unsigned w_data;
    int unsigned w_addr;
    logic        fwft;
    int unsigned afull_th;
    int unsigned aempty_th;
  } fifo_cfg_st;

  localparam int unsigned FIFO_W_ADDR = 3;

  typedef logic [FIFO_W_ADDR:0] ptr_t;
  typedef logic [FIFO_W_ADDR:0] cnt_t;

  function automatic int unsigned depth_of(input int unsigned w_addr);
    return 32'd1 << w_addr;
  endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// ---------------------------------------------------------------------------
// fifo_ram_dp
// Storage array for the FIFO: one synchronous write port, one read port.
// The read is combinational from the array; with REG_RD=1 it is captured in
// an output register on re_i (reset to zero), otherwise it is passed through.
// Ports:
//   clk, rst          clock, asynchronous active-low reset (output reg only)
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i      read enable (registered mode only) and read address
//   rdata_o           read data
// ---------------------------------------------------------------------------
module fifo_ram_dp #(
  parameter int unsigned W_DATA = 5,
  parameter int unsigned W_ADDR = 3,
  parameter bit          REG_RD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [W_ADDR-1:0] waddr_i,
  input  logic [W_DATA-1:0] wdata_i,
  input  logic              re_i,
  input  logic [W_ADDR-1:0] raddr_i,
  output logic [W_DATA-1:0] rdata_o
);

  import fifo_pkg::*;

  localparam int unsigned DEPTH = depth_of(W_ADDR);

  logic [W_DATA-1:0] mem_q [DEPTH];
  logic [W_DATA-1:0] rd_comb;

  // NOTE: the storage array has no reset; occupancy is tracked by the
  // pointers, so stale words are never observable and a reset here would
  // only prevent the array from mapping onto RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rd_comb = mem_q[raddr_i];

  if (REG_RD) begin : g_reg_rd
    logic [W_DATA-1:0] rdata_d, rdata_q;

    // NOTE: combinational logic uses blocking '=' with a default first so
    // no path leaves the variable unassigned (which would infer a latch);
    // state registers use non-blocking '<=' only.
    always_comb begin
      rdata_d = rdata_q;
      if (re_i) rdata_d = rd_comb;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) rdata_q <= '0;
      else      rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;
  end else begin : g_comb_rd
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = ^{re_i, rst};
    assign rdata_o        = rd_comb;
  end

endmodule

// File: rtl/fifo_sync_cfg.sv
// ---------------------------------------------------------------------------
// fifo_sync_cfg
// Single-clock FIFO with configurable width/depth, standard or FWFT read,
// registered occupancy count, programmable almost-full/almost-empty flags,
// sticky overflow/underflow flags and a synchronous flush.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   clear_i             synchronous flush (priority over push/pop)
//   push_i, data_i      write request and data
//   pop_i               read request
//   data_o, valid_o     read data and its qualifier (mode dependent)
//   full_o, empty_o     count == DEPTH / count == 0
//   afull_o, aempty_o   count >= AFULL_TH / count <= AEMPTY_TH
//   count_o             occupancy 0..DEPTH
//   ovf_o, udf_o        sticky rejected-push / rejected-pop flags
// ---------------------------------------------------------------------------
module fifo_sync_cfg #(
  parameter int unsigned W_DATA    = 5,
  parameter int unsigned W_ADDR    = 3,
  parameter bit          FWFT      = 1'b0,
  parameter int unsigned AFULL_TH  = 6,
  parameter int unsigned AEMPTY_TH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [W_DATA-1:0] data_i,
  input  logic              pop_i,
  output logic [W_DATA-1:0] data_o,
  output logic              valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              afull_o,
  output logic              aempty_o,
  output logic [W_ADDR:0]   count_o,
  output logic              ovf_o,
  output logic              udf_o
);

  import fifo_pkg::*;

  localparam fifo_cfg_st CFG = '{
    w_data:    W_DATA,
    w_addr:    W_ADDR,
    fwft:      FWFT,
    afull_th:  AFULL_TH,
    aempty_th: AEMPTY_TH
  };

  localparam rd_mode_e RD_MODE = CFG.fwft ? RD_FWFT : RD_STD;

  // Pointer/count types sized for this instance's address width.
  typedef logic [W_ADDR:0] ptr_w_t;
  typedef logic [W_ADDR:0] cnt_w_t;

  localparam cnt_w_t AFULL_C  = cnt_w_t'(CFG.afull_th);
  localparam cnt_w_t AEMPTY_C = cnt_w_t'(CFG.aempty_th);

  ptr_w_t wr_ptr_d, wr_ptr_q;
  ptr_w_t rd_ptr_d, rd_ptr_q;
  cnt_w_t count_d,  count_q;
  logic   ovf_d,    ovf_q;
  logic   udf_d,    udf_q;
  logic   valid_d,  valid_q;

  logic full, empty;
  logic push_acc, pop_acc;
  logic we, re;
  logic [W_DATA-1:0] ram_rdata;

  // Wrap-bit pointers: equal means empty; same slot on opposite laps means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[W_ADDR] != rd_ptr_q[W_ADDR]) &&
                 (wr_ptr_q[W_ADDR-1:0] == rd_ptr_q[W_ADDR-1:0]);

  // A push at full is still taken when a pop frees the slot in the same
  // edge; a pop at empty is never taken, even alongside a push.
  assign pop_acc  = pop_i & ~empty;
  assign push_acc = push_i & (~full | pop_acc);

  // Flush suppresses storage activity so the read register holds its value.
  assign we = push_acc & ~clear_i;
  assign re = pop_acc  & ~clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    valid_d  = 1'b0;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_acc && !pop_acc) count_d = count_q + 1'b1;
      if (pop_acc && !push_acc) count_d = count_q - 1'b1;
      if (push_i && !push_acc) ovf_d = 1'b1;
      if (pop_i  && !pop_acc)  udf_d = 1'b1;
      valid_d = pop_acc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      valid_q  <= valid_d;
    end
  end

  // The registered read samples the array before the same-edge write lands,
  // so a push+pop at full returns the oldest word.
  fifo_ram_dp #(
    .W_DATA (W_DATA),
    .W_ADDR (W_ADDR),
    .REG_RD (RD_MODE == RD_STD)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .waddr_i (wr_ptr_q[W_ADDR-1:0]),
    .wdata_i (data_i),
    .re_i    (re),
    .raddr_i (rd_ptr_q[W_ADDR-1:0]),
    .rdata_o (ram_rdata)
  );

  if (RD_MODE == RD_FWFT) begin : g_fwft
    logic unused_valid;
    assign unused_valid = valid_q;
    // Gate the head word so an empty FIFO presents zero rather than stale RAM.
    assign data_o  = empty ? '0 : ram_rdata;
    assign valid_o = ~empty;
  end else begin : g_std
    assign data_o  = ram_rdata;
    assign valid_o = valid_q;
  end

  assign full_o   = full;
  assign empty_o  = empty;
  assign afull_o  = (count_q >= AFULL_C);
  assign aempty_o = (count_q <= AEMPTY_C);
  assign count_o  = count_q;
  assign ovf_o    = ovf_q;
  assign udf_o    = udf_q;

endmodule

// File: tb/tb_fifo_sync_cfg.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_cfg
// Directed bench for fifo_sync_cfg: one standard-read instance and one FWFT
// instance (both W_DATA=5, W_ADDR=3, AFULL_TH=6, AEMPTY_TH=1).
// ---------------------------------------------------------------------------
module tb_fifo_sync_cfg;

  logic clk = 1'b0;
  logic rst;

  // Standard-read instance
  logic       s_clear, s_push, s_pop;
  logic [4:0] s_din, s_dout;
  logic       s_valid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
  logic [3:0] s_count;

  // FWFT instance
  logic       f_clear, f_push, f_pop;
  logic [4:0] f_din, f_dout;
  logic       f_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic [3:0] f_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_sync_cfg #(.W_DATA(5), .W_ADDR(3), .FWFT(1'b0), .AFULL_TH(6), .AEMPTY_TH(1)) u_std (
    .clk(clk), .rst(rst), .clear_i(s_clear), .push_i(s_push), .data_i(s_din),
    .pop_i(s_pop), .data_o(s_dout), .valid_o(s_valid), .full_o(s_full),
    .empty_o(s_empty), .afull_o(s_afull), .aempty_o(s_aempty), .count_o(s_count),
    .ovf_o(s_ovf), .udf_o(s_udf)
  );

  fifo_sync_cfg #(.W_DATA(5), .W_ADDR(3), .FWFT(1'b1), .AFULL_TH(6), .AEMPTY_TH(1)) u_fwft (
    .clk(clk), .rst(rst), .clear_i(f_clear), .push_i(f_push), .data_i(f_din),
    .pop_i(f_pop), .data_o(f_dout), .valid_o(f_valid), .full_o(f_full),
    .empty_o(f_empty), .afull_o(f_afull), .aempty_o(f_aempty), .count_o(f_count),
    .ovf_o(f_ovf), .udf_o(f_udf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_std_reset(input string tag);
    check({tag, ".count"},  32'(s_count),  0);
    check({tag, ".empty"},  32'(s_empty),  1);
    check({tag, ".aempty"}, 32'(s_aempty), 1);
    check({tag, ".full"},   32'(s_full),   0);
    check({tag, ".afull"},  32'(s_afull),  0);
    check({tag, ".ovf"},    32'(s_ovf),    0);
    check({tag, ".udf"},    32'(s_udf),    0);
    check({tag, ".valid"},  32'(s_valid),  0);
    check({tag, ".data"},   32'(s_dout),   0);
  endtask

  initial begin
    rst = 1'b0;
    s_clear = 0; s_push = 0; s_pop = 0; s_din = '0;
    f_clear = 0; f_push = 0; f_pop = 0; f_din = '0;

    // Reset state, observed before any clock edge.
    #2;
    check_std_reset("rst_std");
    check("rst_fwft.valid", 32'(f_valid), 0);
    check("rst_fwft.data",  32'(f_dout),  0);
    check("rst_fwft.empty", 32'(f_empty), 1);
    #4 rst = 1'b1;
    tick();

    // Fill with 0x01..0x08.
    for (int i = 1; i <= 8; i++) begin
      s_push = 1; s_din = 5'(i);
      tick();
      check($sformatf("fill%0d.count", i),  32'(s_count),  i);
      check($sformatf("fill%0d.afull", i),  32'(s_afull),  (i >= 6) ? 1 : 0);
      check($sformatf("fill%0d.full", i),   32'(s_full),   (i == 8) ? 1 : 0);
      check($sformatf("fill%0d.aempty", i), 32'(s_aempty), (i <= 1) ? 1 : 0);
      check($sformatf("fill%0d.ovf", i),    32'(s_ovf),    0);
    end

    // Ninth push at full is rejected.
    s_din = 5'h09;
    tick();
    check("ovf.flag",  32'(s_ovf),   1);
    check("ovf.count", 32'(s_count), 8);
    s_push = 0;

    // Drain: each word appears with valid_o one cycle after its pop.
    s_pop = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("drain%0d.valid", i), 32'(s_valid), 1);
      check($sformatf("drain%0d.data", i),  32'(s_dout),  i);
      check($sformatf("drain%0d.count", i), 32'(s_count), 8 - i);
    end
    check("drain.empty", 32'(s_empty), 1);

    // Underflow: pop at empty.
    tick();
    check("udf.flag",  32'(s_udf),   1);
    check("udf.count", 32'(s_count), 0);
    check("udf.valid", 32'(s_valid), 0);
    check("udf.ovf_sticky", 32'(s_ovf), 1);
    s_pop = 0;

    // Flush clears both sticky flags.
    s_clear = 1;
    tick();
    s_clear = 0;
    check("clr.udf",   32'(s_udf),   0);
    check("clr.ovf",   32'(s_ovf),   0);
    check("clr.valid", 32'(s_valid), 0);

    // Refill with 0x11..0x18, then push+pop at full.
    s_push = 1;
    for (int i = 1; i <= 8; i++) begin
      s_din = 5'(8'h10 + i);
      tick();
    end
    check("pf.full", 32'(s_full), 1);
    s_din = 5'h1F; s_pop = 1;
    tick();
    check("pf.count", 32'(s_count), 8);
    check("pf.valid", 32'(s_valid), 1);
    check("pf.data",  32'(s_dout),  32'h11);
    check("pf.ovf",   32'(s_ovf),   0);
    s_pop = 0;

    // Flush with a push in the same cycle: push dropped, no ovf.
    s_clear = 1; s_din = 5'h1E;
    tick();
    s_clear = 0; s_push = 0;
    check("clrpush.count", 32'(s_count), 0);
    check("clrpush.ovf",   32'(s_ovf),   0);
    check("clrpush.empty", 32'(s_empty), 1);
    check("clrpush.data_hold", 32'(s_dout), 32'h11);

    // Push+pop at empty: push taken, pop rejected.
    s_push = 1; s_pop = 1; s_din = 5'h0A;
    tick();
    s_push = 0;
    check("pe.count", 32'(s_count), 1);
    check("pe.udf",   32'(s_udf),   1);
    check("pe.valid", 32'(s_valid), 0);
    tick();
    s_pop = 0;
    check("pe.pop_valid", 32'(s_valid), 1);
    check("pe.pop_data",  32'(s_dout),  32'h0A);
    check("pe.pop_count", 32'(s_count), 0);
    s_clear = 1;
    tick();
    s_clear = 0;

    // FWFT: head word visible one cycle after push, without a pop.
    f_push = 1; f_din = 5'h15;
    tick();
    f_push = 0;
    check("fwft.valid", 32'(f_valid), 1);
    check("fwft.data",  32'(f_dout),  32'h15);
    check("fwft.count", 32'(f_count), 1);
    f_pop = 1;
    tick();
    f_pop = 0;
    check("fwft.pop_valid", 32'(f_valid), 0);
    check("fwft.pop_empty", 32'(f_empty), 1);

    // Wrap: 20 words streamed through; pointers lap the 16-value range.
    for (int k = 0; k <= 20; k++) begin
      s_push = (k < 20);
      s_din  = 5'((k + 3) & 31);
      s_pop  = (k > 0);
      tick();
      if (k > 0) begin
        check($sformatf("wrap%0d.valid", k), 32'(s_valid), 1);
        check($sformatf("wrap%0d.data", k),  32'(s_dout),  (k + 2) & 31);
      end
      check($sformatf("wrap%0d.count", k), 32'(s_count), (k < 20) ? 1 : 0);
    end
    s_push = 0; s_pop = 0;
    check("wrap.ovf",   32'(s_ovf),   0);
    check("wrap.udf",   32'(s_udf),   0);
    check("wrap.empty", 32'(s_empty), 1);

    // Reset mid-burst, asserted between clock edges.
    s_push = 1; s_din = 5'h07;
    tick();
    tick();
    check("burst.count", 32'(s_count), 2);
    #2 rst = 1'b0;
    #1;
    check_std_reset("rst_mid");
    s_push = 0;
    #3 rst = 1'b1;
    tick();
    check("post_rst.count", 32'(s_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
